// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave cook controller: FSM states,
// BCD digit / cook-time types and keypad decode.
package microwave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SET   = 2'd1,
    ST_COOK  = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t mins;
    bcd_t tens;
    bcd_t ones;
  } cook_time_t;

  localparam int NUM_KEYS = 10;

  function automatic logic key_onehot(input logic [NUM_KEYS-1:0] k);
    return (k != '0) && ((k & (k - NUM_KEYS'(1))) == '0);
  endfunction

  // Caller guarantees k is one-hot; highest set bit wins otherwise.
  function automatic bcd_t key_decode(input logic [NUM_KEYS-1:0] k);
    bcd_t d;
    d = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (k[i]) d = bcd_t'(i);
    return d;
  endfunction

endpackage

// File: rtl/bcd_down_counter3.sv
// Three-digit BCD cook-time register: clear, shift-in of a keyed digit and
// m:ss style decrement (borrow from minutes reloads tens with 5).
module bcd_down_counter3
  import microwave_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       shift,
  input  bcd_t       digit,
  input  logic       dec,
  output cook_time_t tm,
  output logic       is_one,
  output logic       is_zero
);

  // Tens may legitimately hold 6-9 from key entry; it simply counts down.
  function automatic cook_time_t dec_time(input cook_time_t t);
    cook_time_t r;
    r = t;
    if (t.ones != 4'd0) begin
      r.ones = t.ones - 4'd1;
    end else if (t.tens != 4'd0) begin
      r.tens = t.tens - 4'd1;
      r.ones = 4'd9;
    end else begin
      r.mins = t.mins - 4'd1;
      r.tens = 4'd5;
      r.ones = 4'd9;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr)
      tm <= '0;
    else if (shift)
      tm <= '{mins: tm.tens, tens: tm.ones, ones: digit};
    else if (dec)
      tm <= dec_time(tm);
  end

  assign is_zero = (tm == 12'h000);
  assign is_one  = (tm == 12'h001);

endmodule

// File: rtl/microwave_ctrl.sv
// Cook-cycle controller: front-panel edge detection, seconds prescaler and
// cook FSM driving the BCD time display and magnetron enable.
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50  // must be >= 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                startn,
  input  logic                stopn,
  input  logic                clearn,
  input  logic                door_closed,
  output logic                mag,
  output logic [3:0]          sec_ones,
  output logic [3:0]          sec_tens,
  output logic [3:0]          mins,
  output logic                done,
  output logic [1:0]          state
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);

  state_e              st, nxt;
  logic [NUM_KEYS-1:0] keypad_q;
  logic                startn_q, stopn_q;
  logic [PW-1:0]       presc;
  cook_time_t          tm;
  bcd_t                key_digit;
  logic                cnt_one, cnt_zero;
  logic                cnt_clr, cnt_shift, cnt_dec, done_nxt;
  logic                key_ev, start_ev, stop_ev, clr_lvl, sec_tick, shift_nz;

  assign key_ev    = (keypad_q == '0) && key_onehot(keypad);
  assign start_ev  = startn_q & ~startn;
  assign stop_ev   = stopn_q & ~stopn;
  assign clr_lvl   = ~clearn;
  assign sec_tick  = (presc == LAST_TICK);
  assign key_digit = key_decode(keypad);
  assign shift_nz  = ({tm.tens, tm.ones, key_digit} != '0);

  // Priority chain: clear > door open > stop > start > tick > key.
  // A start edge always swallows a same-cycle key, even when start is ignored.
  always_comb begin
    nxt       = st;
    cnt_clr   = 1'b0;
    cnt_shift = 1'b0;
    cnt_dec   = 1'b0;
    done_nxt  = 1'b0;
    if (clr_lvl) begin
      nxt     = ST_IDLE;
      cnt_clr = 1'b1;
    end else if (st == ST_COOK && !door_closed) begin
      nxt = ST_PAUSE;
    end else if (stop_ev && st != ST_IDLE) begin
      if (st == ST_COOK) begin
        nxt = ST_PAUSE;
      end else begin
        nxt     = ST_IDLE;
        cnt_clr = 1'b1;
      end
    end else if (start_ev && (st == ST_SET || st == ST_PAUSE) && door_closed && !cnt_zero) begin
      nxt = ST_COOK;
    end else if (st == ST_COOK && sec_tick) begin
      if (cnt_one) begin
        nxt      = ST_IDLE;
        cnt_clr  = 1'b1;
        done_nxt = 1'b1;
      end else begin
        cnt_dec = 1'b1;
      end
    end else if (key_ev && !start_ev && (st == ST_IDLE || st == ST_SET)) begin
      cnt_shift = 1'b1;
      nxt       = shift_nz ? ST_SET : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      done     <= 1'b0;
      presc    <= '0;
      keypad_q <= '0;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
    end else begin
      st       <= nxt;
      done     <= done_nxt;
      keypad_q <= keypad;
      startn_q <= startn;
      stopn_q  <= stopn;
      // Every COOK entry restarts the second so a resume gets a full second.
      if (nxt == ST_COOK && st != ST_COOK)
        presc <= '0;
      else if (st == ST_COOK && nxt == ST_COOK)
        presc <= sec_tick ? '0 : presc + PW'(1);
    end
  end

  bcd_down_counter3 u_time (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .shift   (cnt_shift),
    .digit   (key_digit),
    .dec     (cnt_dec),
    .tm      (tm),
    .is_one  (cnt_one),
    .is_zero (cnt_zero)
  );

  // Combinational so the magnetron drops in the very cycle the door opens.
  assign mag      = (st == ST_COOK) && door_closed;
  assign sec_ones = tm.ones;
  assign sec_tens = tm.tens;
  assign mins     = tm.mins;
  assign state    = st;

endmodule
